mult_div_unit: RTL and testbench

- Iterative radix-2 multiply/divide unit in the execute stage, beside the ALU.
- Consumes the same rs/rt operands the ALU receives and owns the architectural HI/LO registers for MULT, MULTU, DIV, DIVU, MTHI, MTLO.
- MFHI/MFLO read hi/lo combinationally through the ALU PASSX path.
- Asserts busy so hazard logic stalls the pipeline while an operation is in flight.

---
 rtl/mult_div_unit.sv | 190 +++++++++++++++++++
 tb/tb_mult_div_unit.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative radix-2 multiply/divide unit that owns HI/LO.
// Multiply is MSB-first shift-add on operand magnitudes; divide is restoring
// shift-subtract. Signs are applied once in FIX, after the magnitude loop.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             md_start,
  input  logic [1:0]       md_op,
  input  logic [WIDTH-1:0] md_op_x,
  input  logic [WIDTH-1:0] md_op_y,
  input  logic             md_kill,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] mt_data,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] OP_MULT = 2'b00;
  localparam logic [1:0] OP_DIV  = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIX  = 2'b10
  } state_t;

  state_t             state_q;
  logic [1:0]         op_q;
  logic               sign_x_q;
  logic               sign_y_q;
  logic [WIDTH-1:0]   x_q;
  logic [WIDTH-1:0]   y_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [CW-1:0]      cnt_q;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;
  logic               busy_q;
  logic               done_q;
  logic               dbz_q;

  logic               start_signed;
  logic               neg_x;
  logic               neg_y;
  logic [WIDTH-1:0]   mag_x;
  logic [WIDTH-1:0]   mag_y;
  logic [WIDTH:0]     rem_trial;
  logic [2*WIDTH-1:0] acc_d;
  logic [WIDTH-1:0]   x_d;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;
  logic [WIDTH-1:0]   fix_hi_d;
  logic [WIDTH-1:0]   fix_lo_d;

  // Operand magnitudes and signs captured when a new operation starts.
  always_comb begin
    start_signed = ~md_op[0];
    neg_x        = start_signed & md_op_x[WIDTH-1];
    neg_y        = start_signed & md_op_y[WIDTH-1];
    mag_x        = neg_x ? (-md_op_x) : md_op_x;
    mag_y        = neg_y ? (-md_op_y) : md_op_y;
  end

  // One iteration step: x_q shifts out its MSB as multiplier bit or dividend bit.
  always_comb begin
    x_d       = {x_q[WIDTH-2:0], 1'b0};
    rem_trial = {acc_q[2*WIDTH-2:WIDTH], x_q[WIDTH-1]} - {1'b0, y_q};
    acc_d     = acc_q;
    if (op_q[1]) begin
      if (!rem_trial[WIDTH]) begin
        acc_d = {rem_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
      end else begin
        acc_d = {acc_q[2*WIDTH-2:WIDTH], x_q[WIDTH-1], acc_q[WIDTH-2:0], 1'b0};
      end
    end else begin
      acc_d = {acc_q[2*WIDTH-2:0], 1'b0}
            + (x_q[WIDTH-1] ? {{WIDTH{1'b0}}, y_q} : {2*WIDTH{1'b0}});
    end
  end

  // Sign correction of the magnitude result applied in FIX.
  always_comb begin
    prod_fix = acc_q;
    quo_fix  = acc_q[WIDTH-1:0];
    rem_fix  = acc_q[2*WIDTH-1:WIDTH];
    if (op_q == OP_MULT && (sign_x_q ^ sign_y_q)) begin
      prod_fix = -acc_q;
    end
    if (op_q == OP_DIV) begin
      if (sign_x_q ^ sign_y_q) begin
        quo_fix = -acc_q[WIDTH-1:0];
      end
      if (sign_x_q) begin
        rem_fix = -acc_q[2*WIDTH-1:WIDTH];
      end
    end
    if (op_q[1]) begin
      fix_hi_d = rem_fix;
      fix_lo_d = quo_fix;
    end else begin
      fix_hi_d = prod_fix[2*WIDTH-1:WIDTH];
      fix_lo_d = prod_fix[WIDTH-1:0];
    end
  end

  // Control FSM with registered busy/done/div_by_zero and the HI/LO registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      op_q     <= 2'b00;
      sign_x_q <= 1'b0;
      sign_y_q <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      dbz_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (hi_we) begin
            hi_q <= mt_data;
          end
          if (lo_we) begin
            lo_q <= mt_data;
          end
          if (md_start && !md_kill) begin
            op_q     <= md_op;
            x_q      <= mag_x;
            y_q      <= mag_y;
            sign_x_q <= neg_x;
            sign_y_q <= neg_y;
            acc_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
            state_q  <= RUN;
          end
        end
        RUN: begin
          if (md_kill) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            acc_q <= acc_d;
            x_q   <= x_d;
            cnt_q <= cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH - 1)) begin
              state_q <= FIX;
            end
          end
        end
        FIX: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
          if (!md_kill) begin
            hi_q   <= fix_hi_d;
            lo_q   <= fix_lo_d;
            done_q <= 1'b1;
            dbz_q  <= op_q[1] && (y_q == '0);
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: directed tests for mult_div_unit against a cycle-count
// model that computes results with plain 64-bit arithmetic.
module tb_mult_div_unit;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          md_start = 1'b0;
  logic [1:0]    md_op = 2'b00;
  logic [W-1:0]  md_op_x = '0;
  logic [W-1:0]  md_op_y = '0;
  logic          md_kill = 1'b0;
  logic          hi_we = 1'b0;
  logic          lo_we = 1'b0;
  logic [W-1:0]  mt_data = '0;
  logic          busy;
  logic          done;
  logic          div_by_zero;
  logic [W-1:0]  hi;
  logic [W-1:0]  lo;

  int compared   = 0;
  int mismatched = 0;

  logic          mBusy   = 1'b0;
  logic          mDone   = 1'b0;
  logic          mDbz    = 1'b0;
  logic [W-1:0]  mHi     = '0;
  logic [W-1:0]  mLo     = '0;
  int            mRemain = 0;
  logic [63:0]   mResult = '0;
  logic          mResDbz = 1'b0;

  int            bc;
  bit            ok;

  mult_div_unit #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .md_start   (md_start),
    .md_op      (md_op),
    .md_op_x    (md_op_x),
    .md_op_y    (md_op_y),
    .md_kill    (md_kill),
    .hi_we      (hi_we),
    .lo_we      (lo_we),
    .mt_data    (mt_data),
    .busy       (busy),
    .done       (done),
    .div_by_zero(div_by_zero),
    .hi         (hi),
    .lo         (lo)
  );

  always #5 clk = ~clk;

  // Architectural result {hi, lo} of one operation from plain arithmetic.
  function automatic logic [63:0] modelResult(input logic [1:0] op,
                                              input logic [31:0] x,
                                              input logic [31:0] y);
    longint      a;
    longint      b;
    longint      q;
    longint      r;
    logic [63:0] res;
    res = '0;
    case (op)
      2'b00: begin
        a   = longint'($signed(x));
        b   = longint'($signed(y));
        res = a * b;
      end
      2'b01: begin
        res = {32'b0, x} * {32'b0, y};
      end
      2'b10: begin
        if (y == 32'h0) begin
          res = {x, (x[31] ? 32'h0000_0001 : 32'hFFFF_FFFF)};
        end else begin
          a   = longint'($signed(x));
          b   = longint'($signed(y));
          q   = a / b;
          r   = a % b;
          res = {r[31:0], q[31:0]};
        end
      end
      default: begin
        if (y == 32'h0) begin
          res = {x, 32'hFFFF_FFFF};
        end else begin
          res = {x % y, x / y};
        end
      end
    endcase
    return res;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] op, input logic [31:0] x,
                               input logic [31:0] y);
    md_op    = op;
    md_op_x  = x;
    md_op_y  = y;
    md_start = 1'b1;
    @(negedge clk);
    md_start = 1'b0;
  endtask

  task automatic waitDone(output int busyCycles, output bit seen);
    busyCycles = 0;
    seen       = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done === 1'b1) begin
        seen = 1'b1;
        break;
      end
      if (busy === 1'b1) busyCycles++;
      @(negedge clk);
    end
    compared++;
    if (!seen) begin
      mismatched++;
      $display("[TB] FAIL done_timeout: got no done, expected done within 40 cycles");
    end
  endtask

  // Model: an accepted start produces its result 33 edges later unless killed.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mBusy   = 1'b0;
      mDone   = 1'b0;
      mDbz    = 1'b0;
      mHi     = '0;
      mLo     = '0;
      mRemain = 0;
    end else begin
      mDone = 1'b0;
      mDbz  = 1'b0;
      if (!mBusy) begin
        if (hi_we) mHi = mt_data;
        if (lo_we) mLo = mt_data;
        if (md_start && !md_kill) begin
          mResult = modelResult(md_op, md_op_x, md_op_y);
          mResDbz = md_op[1] && (md_op_y == '0);
          mBusy   = 1'b1;
          mRemain = W + 1;
        end
      end else if (md_kill) begin
        mBusy = 1'b0;
      end else begin
        mRemain--;
        if (mRemain == 0) begin
          mHi   = mResult[63:32];
          mLo   = mResult[31:0];
          mDone = 1'b1;
          mDbz  = mResDbz;
          mBusy = 1'b0;
        end
      end
    end
  end

  // Every cycle out of reset, all outputs must match the model.
  always @(negedge clk) begin
    if (!rst) begin
      checkOutput("cyc_busy", 64'(busy), 64'(mBusy));
      checkOutput("cyc_done", 64'(done), 64'(mDone));
      checkOutput("cyc_dbz", 64'(div_by_zero), 64'(mDbz));
      checkOutput("cyc_hi", 64'(hi), 64'(mHi));
      checkOutput("cyc_lo", 64'(lo), 64'(mLo));
    end
  end

  initial begin
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("reset_hi", 64'(hi), 64'h0);
    checkOutput("reset_lo", 64'(lo), 64'h0);
    checkOutput("reset_busy", 64'(busy), 64'h0);
    checkOutput("reset_done", 64'(done), 64'h0);
    checkOutput("reset_dbz", 64'(div_by_zero), 64'h0);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] MULTU 0xFFFFFFFF x 0xFFFFFFFF");
    applyStimulus(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    waitDone(bc, ok);
    checkOutput("multu_busy_cycles", 64'(bc), 64'd33);
    checkOutput("multu_hi", 64'(hi), 64'h0000_0000_FFFF_FFFE);
    checkOutput("multu_lo", 64'(lo), 64'h0000_0000_0000_0001);

    $display("[TB] MULT -2 x 3, then back-to-back DIVU 100/7");
    @(negedge clk);
    applyStimulus(2'b00, 32'hFFFF_FFFE, 32'h0000_0003);
    waitDone(bc, ok);
    checkOutput("mult_hi", 64'(hi), 64'h0000_0000_FFFF_FFFF);
    checkOutput("mult_lo", 64'(lo), 64'h0000_0000_FFFF_FFFA);
    applyStimulus(2'b11, 32'd100, 32'd7);
    waitDone(bc, ok);
    checkOutput("divu_b2b_hi", 64'(hi), 64'd2);
    checkOutput("divu_b2b_lo", 64'(lo), 64'd14);

    $display("[TB] DIV -7/2 and DIV 0x80000000/-1");
    @(negedge clk);
    applyStimulus(2'b10, 32'hFFFF_FFF9, 32'h0000_0002);
    waitDone(bc, ok);
    checkOutput("div_neg_hi", 64'(hi), 64'h0000_0000_FFFF_FFFF);
    checkOutput("div_neg_lo", 64'(lo), 64'h0000_0000_FFFF_FFFD);
    @(negedge clk);
    applyStimulus(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    waitDone(bc, ok);
    checkOutput("div_ovf_hi", 64'(hi), 64'h0);
    checkOutput("div_ovf_lo", 64'(lo), 64'h0000_0000_8000_0000);

    $display("[TB] DIVU by zero");
    @(negedge clk);
    applyStimulus(2'b11, 32'h1234_5678, 32'h0);
    waitDone(bc, ok);
    checkOutput("dbz_busy_cycles", 64'(bc), 64'd33);
    checkOutput("dbz_flag", 64'(div_by_zero), 64'h1);
    checkOutput("dbz_hi", 64'(hi), 64'h0000_0000_1234_5678);
    checkOutput("dbz_lo", 64'(lo), 64'h0000_0000_FFFF_FFFF);

    $display("[TB] kill MULTU 5x5 in RUN cycle 10");
    @(negedge clk);
    applyStimulus(2'b01, 32'd5, 32'd5);
    repeat (9) @(negedge clk);
    md_kill = 1'b1;
    @(negedge clk);
    md_kill = 1'b0;
    checkOutput("kill_busy", 64'(busy), 64'h0);
    checkOutput("kill_done", 64'(done), 64'h0);
    repeat (40) @(negedge clk);
    checkOutput("kill_hi", 64'(hi), 64'h0000_0000_1234_5678);
    checkOutput("kill_lo", 64'(lo), 64'h0000_0000_FFFF_FFFF);

    $display("[TB] start pulse while busy is ignored");
    applyStimulus(2'b01, 32'd6, 32'd7);
    repeat (5) @(negedge clk);
    md_op    = 2'b10;
    md_op_x  = 32'd99;
    md_op_y  = 32'd3;
    md_start = 1'b1;
    @(negedge clk);
    md_start = 1'b0;
    waitDone(bc, ok);
    checkOutput("ignore_hi", 64'(hi), 64'h0);
    checkOutput("ignore_lo", 64'(lo), 64'd42);

    $display("[TB] MTHI/MTLO in IDLE and while busy");
    @(negedge clk);
    hi_we   = 1'b1;
    mt_data = 32'hAAAA_0000;
    @(negedge clk);
    hi_we = 1'b0;
    checkOutput("mthi", 64'(hi), 64'h0000_0000_AAAA_0000);
    lo_we   = 1'b1;
    mt_data = 32'h0000_5555;
    @(negedge clk);
    lo_we = 1'b0;
    checkOutput("mtlo", 64'(lo), 64'h0000_0000_0000_5555);
    applyStimulus(2'b01, 32'd3, 32'd4);
    repeat (3) @(negedge clk);
    hi_we   = 1'b1;
    lo_we   = 1'b1;
    mt_data = 32'hDEAD_BEEF;
    @(negedge clk);
    hi_we = 1'b0;
    lo_we = 1'b0;
    checkOutput("mt_busy_hi", 64'(hi), 64'h0000_0000_AAAA_0000);
    checkOutput("mt_busy_lo", 64'(lo), 64'h0000_0000_0000_5555);
    waitDone(bc, ok);
    checkOutput("mt_busy_res_lo", 64'(lo), 64'd12);

    $display("[TB] MTHI together with start");
    @(negedge clk);
    hi_we   = 1'b1;
    mt_data = 32'h1111_1111;
    applyStimulus(2'b01, 32'd2, 32'd3);
    hi_we = 1'b0;
    checkOutput("mt_start_hi", 64'(hi), 64'h0000_0000_1111_1111);
    waitDone(bc, ok);
    checkOutput("mt_start_res_hi", 64'(hi), 64'h0);
    checkOutput("mt_start_res_lo", 64'(lo), 64'd6);

    $display("[TB] reset mid-RUN");
    @(negedge clk);
    applyStimulus(2'b00, 32'd7, 32'd9);
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("rst_mid_hi", 64'(hi), 64'h0);
    checkOutput("rst_mid_lo", 64'(lo), 64'h0);
    checkOutput("rst_mid_busy", 64'(busy), 64'h0);
    checkOutput("rst_mid_done", 64'(done), 64'h0);
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
